// File: rtl/enemy_vector_sequencer.sv
// Turns up to three enemy positions into a diamond-marker vector list over a valid/ready link.
// Define ENEMY_VEC_CROSS_EN to add a cross inside each diamond (9 points per enemy instead of 5).
module enemy_vector_sequencer #(
   parameter int OUT_WIDTH = 8,
   parameter int MARKER_R  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   output logic                 busy,
   input  logic [OUT_WIDTH-1:0] xenemy1,
   input  logic [OUT_WIDTH-1:0] yenemy1,
   input  logic                 spawn_enemy1,
   input  logic [OUT_WIDTH-1:0] xenemy2,
   input  logic [OUT_WIDTH-1:0] yenemy2,
   input  logic                 spawn_enemy2,
   input  logic [OUT_WIDTH-1:0] xenemy3,
   input  logic [OUT_WIDTH-1:0] yenemy3,
   input  logic                 spawn_enemy3,
   output logic [OUT_WIDTH-1:0] vec_x,
   output logic [OUT_WIDTH-1:0] vec_y,
   output logic                 vec_draw,
   output logic                 vec_valid,
   input  logic                 vec_ready,
   output logic                 frame_done
);

   localparam int W = OUT_WIDTH;
   localparam logic [W-1:0] R = W'(MARKER_R);
`ifdef ENEMY_VEC_CROSS_EN
   localparam logic [3:0] LAST_PT = 4'd8;
`else
   localparam logic [3:0] LAST_PT = 4'd4;
`endif

   typedef enum logic [1:0] {IDLE, SELECT, EMIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0][W-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
   logic [2:0]        snap_s_q, snap_s_d;
   logic [1:0]        cur_q, cur_d;
   logic [3:0]        pt_q, pt_d;
   logic [W-1:0]      vec_x_q, vec_x_d, vec_y_q, vec_y_d;
   logic              vec_draw_q, vec_draw_d, vec_valid_q, vec_valid_d;
   logic              busy_q, busy_d, frame_done_q, frame_done_d;
   logic [2:0]        sel_from, nxt;
   logic [2*W:0]      pt_vec;

   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, R};
      return s[W] ? {W{1'b1}} : s[W-1:0];
   endfunction

   function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a);
      return (a < R) ? '0 : a - R;
   endfunction

   // Returns {x, y, draw} for point k of the marker around (x, y).
   function automatic logic [2*W:0] vertex(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [3:0] k);
      logic [2*W:0] v;
      case (k)
         4'd1:    v = {sat_add(x), y, 1'b1};
         4'd2:    v = {x, sat_sub(y), 1'b1};
         4'd3:    v = {sat_sub(x), y, 1'b1};
         4'd4:    v = {x, sat_add(y), 1'b1};
`ifdef ENEMY_VEC_CROSS_EN
         4'd5:    v = {sat_sub(x), y, 1'b0};
         4'd6:    v = {sat_add(x), y, 1'b1};
         4'd7:    v = {x, sat_add(y), 1'b0};
         4'd8:    v = {x, sat_sub(y), 1'b1};
`endif
         default: v = {x, sat_add(y), 1'b0};
      endcase
      return v;
   endfunction

   // Lowest spawned index >= from; bit 2 flags that one was found.
   function automatic logic [2:0] next_enemy(input logic [2:0] spawn, input logic [2:0] from);
      logic [2:0] r;
      r = '0;
      for (int i = 2; i >= 0; i--)
         if (spawn[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
      return r;
   endfunction

   always_comb begin
      state_d      = state_q;
      snap_x_d     = snap_x_q;
      snap_y_d     = snap_y_q;
      snap_s_d     = snap_s_q;
      cur_d        = cur_q;
      pt_d         = pt_q;
      vec_x_d      = vec_x_q;
      vec_y_d      = vec_y_q;
      vec_draw_d   = vec_draw_q;
      vec_valid_d  = vec_valid_q;
      busy_d       = busy_q;
      frame_done_d = frame_done_q;
      sel_from     = 3'd0;
      nxt          = '0;
      pt_vec       = '0;
      case (state_q)
         IDLE: if (frame_start) begin
            snap_x_d = {xenemy3, xenemy2, xenemy1};
            snap_y_d = {yenemy3, yenemy2, yenemy1};
            snap_s_d = {spawn_enemy3, spawn_enemy2, spawn_enemy1};
            state_d  = SELECT;
         end
         EMIT: if (vec_ready) begin
            if (pt_q != LAST_PT) begin
               pt_d   = pt_q + 4'd1;
               pt_vec = vertex(snap_x_q[cur_q], snap_y_q[cur_q], pt_d);
               {vec_x_d, vec_y_d, vec_draw_d} = pt_vec;
            end else begin
               state_d  = SELECT;
               sel_from = {1'b0, cur_q} + 3'd1;
            end
         end
         DONE: begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      // SELECT is resolved in the same cycle it is entered so the sink sees no gap.
      if (state_d == SELECT) begin
         nxt = next_enemy(snap_s_d, sel_from);
         busy_d = 1'b1;
         if (nxt[2]) begin
            state_d     = EMIT;
            cur_d       = nxt[1:0];
            pt_d        = 4'd0;
            pt_vec      = vertex(snap_x_d[nxt[1:0]], snap_y_d[nxt[1:0]], 4'd0);
            {vec_x_d, vec_y_d, vec_draw_d} = pt_vec;
            vec_valid_d = 1'b1;
         end else begin
            state_d      = DONE;
            vec_valid_d  = 1'b0;
            frame_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         snap_x_q     <= '0;
         snap_y_q     <= '0;
         snap_s_q     <= '0;
         cur_q        <= '0;
         pt_q         <= '0;
         vec_x_q      <= '0;
         vec_y_q      <= '0;
         vec_draw_q   <= 1'b0;
         vec_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_x_q     <= snap_x_d;
         snap_y_q     <= snap_y_d;
         snap_s_q     <= snap_s_d;
         cur_q        <= cur_d;
         pt_q         <= pt_d;
         vec_x_q      <= vec_x_d;
         vec_y_q      <= vec_y_d;
         vec_draw_q   <= vec_draw_d;
         vec_valid_q  <= vec_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign vec_x      = vec_x_q;
   assign vec_y      = vec_y_q;
   assign vec_draw   = vec_draw_q;
   assign vec_valid  = vec_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
